// File: rtl/fsm_detect_sched.sv
// Round-robin time-shared "RUN_LEN consecutive ones" detector for NCH serial bit streams.
// Optional per-channel saturating hit counters with a read port when FSM_DETECT_SCHED_HITCNT_EN is defined.
module fsm_detect_sched #(
  parameter int NCH     = 4,
  parameter int RUN_LEN = 2,
  parameter int CW      = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] in_valid,
  input  logic [NCH-1:0] in_bit,
  output logic [NCH-1:0] in_ready,
  input  logic [NCH-1:0] clr,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CW-1:0]  out_ch,
  output logic           out_hit
`ifdef FSM_DETECT_SCHED_HITCNT_EN
  ,
  input  logic [CW-1:0]  rd_ch,
  output logic [7:0]     rd_cnt
`endif
);

  localparam int CNTW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

  state_t             state_r;
  logic [CW-1:0]      rr_r;
  logic [CNTW-1:0]    cnt_r [NCH];
  logic               out_valid_r;
  logic [CW-1:0]      out_ch_r;
  logic               out_hit_r;

  logic               grant_en_s;
  logic               gnt_found_s;
  logic [CW-1:0]      gnt_idx_s;
  logic               grant_s;
  logic [NCH-1:0]     in_ready_s;
  logic [CNTW-1:0]    base_cnt_s;
  logic               gnt_bit_s;
  logic               hit_s;
  logic [CNTW-1:0]    nxt_cnt_s;
  logic [CW-1:0]      rr_nxt_s;

  // Round-robin search from rr; a stalled result blocks grants unless it drains this cycle
  always_comb begin
    grant_en_s  = (state_r == IDLE) || out_ready;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (!gnt_found_s && in_valid[(int'(rr_r) + k) % NCH]) begin
        gnt_found_s = 1'b1;
        gnt_idx_s   = CW'((int'(rr_r) + k) % NCH);
      end else begin
        gnt_found_s = gnt_found_s;
      end
    end
    in_ready_s = '0;
    if (grant_en_s && gnt_found_s && !reset) begin
      in_ready_s[gnt_idx_s] = 1'b1;
    end else begin
      in_ready_s = '0;
    end
    grant_s = |in_ready_s;
    if (gnt_idx_s == CW'(NCH - 1)) begin
      rr_nxt_s = '0;
    end else begin
      rr_nxt_s = gnt_idx_s + CW'(1);
    end
  end

  // Shared detector step; a same-cycle clear makes the bit see an empty context
  always_comb begin
    gnt_bit_s = in_bit[gnt_idx_s];
    if (clr[gnt_idx_s]) begin
      base_cnt_s = '0;
    end else begin
      base_cnt_s = cnt_r[gnt_idx_s];
    end
    if (!gnt_bit_s) begin
      hit_s     = 1'b0;
      nxt_cnt_s = '0;
    end else if (base_cnt_s == CNTW'(RUN_LEN - 1)) begin
      hit_s     = 1'b1;
      nxt_cnt_s = '0;
    end else begin
      hit_s     = 1'b0;
      nxt_cnt_s = base_cnt_s + CNTW'(1);
    end
  end

  // Output FSM, result register and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      out_ch_r    <= '0;
      out_hit_r   <= 1'b0;
      rr_r        <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            state_r     <= ACTIVE;
            out_valid_r <= 1'b1;
          end else begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        ACTIVE, STALL: begin
          if (out_ready && grant_s) begin
            state_r     <= ACTIVE;
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
          end else begin
            state_r     <= STALL;
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
      if (grant_s) begin
        out_ch_r  <= gnt_idx_s;
        out_hit_r <= hit_s;
        rr_r      <= rr_nxt_s;
      end else begin
        out_ch_r  <= out_ch_r;
        out_hit_r <= out_hit_r;
        rr_r      <= rr_r;
      end
    end
  end

  // Per-channel run contexts: write-back of the granted channel, otherwise clear or hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (grant_s && (gnt_idx_s == CW'(i))) begin
          cnt_r[i] <= nxt_cnt_s;
        end else if (clr[i]) begin
          cnt_r[i] <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_ch    = out_ch_r;
  assign out_hit   = out_hit_r;

`ifdef FSM_DETECT_SCHED_HITCNT_EN
  logic [7:0] hcnt_r [NCH];

  // Saturating hit counters, loaded on the same edge as the hit result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) hcnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          hcnt_r[i] <= '0;
        end else if (grant_s && hit_s && (gnt_idx_s == CW'(i)) && (hcnt_r[i] != 8'd255)) begin
          hcnt_r[i] <= hcnt_r[i] + 8'd1;
        end else begin
          hcnt_r[i] <= hcnt_r[i];
        end
      end
    end
  end

  // Counter read mux; out-of-range channels read as zero
  always_comb begin
    if (int'(rd_ch) < NCH) begin
      rd_cnt = hcnt_r[rd_ch];
    end else begin
      rd_cnt = 8'd0;
    end
  end
`endif

endmodule
